// File: rtl/scope_capture_ctrl_if.sv
// Purpose : bundles the data, control and status signals of scope_capture_ctrl.
// Latency : n/a (signal bundle only).
// Backpressure: none; SAMPLE is valid every cycle and DISP_ACK is a level.
// Ports (master = capture controller side, slave = ADC/display side):
//   sample, trig_level, trig_fall, mode, arm, disp_ack [, holdoff] -> controller
//   wr_en, wr_addr, wr_data, start_addr, forced, done, state       <- controller
// Optional: holdoff exists only when CAPTURE_HOLDOFF_EN is defined.
// AW must match the AW parameter of the attached scope_capture_ctrl.
interface scope_capture_ctrl_if #(
  parameter int AW = 14
) ();
  logic [11:0]   sample;
  logic [11:0]   trig_level;
  logic          trig_fall;
  logic [1:0]    mode;
  logic          arm;
  logic          disp_ack;
`ifdef CAPTURE_HOLDOFF_EN
  logic [15:0]   holdoff;
`endif
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [11:0]   wr_data;
  logic [AW-1:0] start_addr;
  logic          forced;
  logic          done;
  logic [2:0]    state;

  modport master (
`ifdef CAPTURE_HOLDOFF_EN
    input  holdoff,
`endif
    input  sample, trig_level, trig_fall, mode, arm, disp_ack,
    output wr_en, wr_addr, wr_data, start_addr, forced, done, state
  );

  modport slave (
`ifdef CAPTURE_HOLDOFF_EN
    output holdoff,
`endif
    output sample, trig_level, trig_fall, mode, arm, disp_ack,
    input  wr_en, wr_addr, wr_data, start_addr, forced, done, state
  );
endinterface

// File: rtl/scope_capture_ctrl.sv
// Purpose : single-channel acquisition sequencer; writes a circular sample buffer
//           and freezes a frame of DEPTH samples around a level/edge trigger.
// Latency : WR_DATA is SAMPLE delayed one cycle; all outputs are registered.
// Backpressure: none on the sample stream; a frozen frame is held until DISP_ACK.
// Ports:
//   cs_i  : sample clock (rising edge)       rst_i : synchronous reset, active-high
//   bus   : scope_capture_ctrl_if.master (inputs SAMPLE/TRIG_*/MODE/ARM/DISP_ACK,
//           outputs WR_EN/WR_ADDR/WR_DATA/START_ADDR/FORCED/DONE/STATE)
// Build option: define CAPTURE_HOLDOFF_EN to add bus.holdoff, which suppresses
//   trigger detection (and the auto timeout count) for HOLDOFF cycles after ARMED
//   is entered. Undefined: detection starts in the first ARMED cycle.
// Parameter constraints: 8 <= DEPTH <= 16383, 1 <= PRE < DEPTH, 2**AW >= DEPTH.
module scope_capture_ctrl #(
  parameter int DEPTH   = 15360,
  parameter int PRE     = 3840,
  parameter int AW      = 14,
  parameter int AUTO_TO = 65535
) (
  input  logic                 cs_i,
  input  logic                 rst_i,
  scope_capture_ctrl_if.master bus
);

  // Writes that follow the trigger write inside one frame.
  localparam int POST_N    = DEPTH - PRE - 1;
  localparam int POST_LAST = (POST_N > 0) ? POST_N - 1 : 0;
  localparam int TW        = $clog2(AUTO_TO + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  state_t        state_q;
  logic          wr_en_q;
  logic [AW-1:0] wr_addr_q;
  logic [11:0]   wr_data_q;
  logic [11:0]   prev_q;        // WR_DATA of the previous cycle
  logic          prev_vld_q;    // prev_q belongs to the current frame
  logic [AW-1:0] cnt_q;         // FILL / POST write counter
  logic [TW-1:0] to_cnt_q;      // detection-enabled ARMED cycles, saturating
  logic [AW-1:0] trig_start_q;  // frame start captured at the trigger
  logic          trig_forced_q;
  logic [AW-1:0] start_addr_q;
  logic          forced_q;
  logic          done_q;
`ifdef CAPTURE_HOLDOFF_EN
  logic [15:0]   hold_cnt_q;
`endif

  logic          det_en;
  logic          rise_hit;
  logic          fall_hit;
  logic          real_trig;
  logic          auto_trig;
  logic          go_fill;
  logic [AW-1:0] addr_inc;
  logic [AW-1:0] trig_start;

  always_comb begin
`ifdef CAPTURE_HOLDOFF_EN
    det_en = (hold_cnt_q >= bus.holdoff);
`else
    det_en = 1'b1;
`endif
    rise_hit  = prev_vld_q && (prev_q <  bus.trig_level) && (wr_data_q >= bus.trig_level);
    fall_hit  = prev_vld_q && (prev_q >= bus.trig_level) && (wr_data_q <  bus.trig_level);
    real_trig = (state_q == S_ARMED) && det_en && (bus.trig_fall ? fall_hit : rise_hit);
    auto_trig = (state_q == S_ARMED) && det_en && (bus.mode == 2'd0) &&
                (to_cnt_q >= TW'(AUTO_TO));
    go_fill   = (bus.mode == 2'd0) || (bus.mode == 2'd1) || ((bus.mode == 2'd2) && bus.arm);
    addr_inc  = (wr_addr_q == AW'(DEPTH - 1)) ? '0 : wr_addr_q + AW'(1);
    // Oldest sample of the frame is PRE writes before the trigger write.
    // Add DEPTH instead of going negative when the subtraction would wrap.
    if (wr_addr_q >= AW'(PRE)) begin
      trig_start = wr_addr_q - AW'(PRE);
    end else begin
      trig_start = AW'({1'b0, wr_addr_q} + (AW+1)'(DEPTH - PRE));
    end
  end

  always_ff @(posedge cs_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      prev_q        <= '0;
      prev_vld_q    <= 1'b0;
      cnt_q         <= '0;
      to_cnt_q      <= '0;
      trig_start_q  <= '0;
      trig_forced_q <= 1'b0;
      start_addr_q  <= '0;
      forced_q      <= 1'b0;
      done_q        <= 1'b0;
`ifdef CAPTURE_HOLDOFF_EN
      hold_cnt_q    <= '0;
`endif
    end else begin
      wr_data_q <= bus.sample;
      prev_q    <= wr_data_q;
      if (wr_en_q) begin
        wr_addr_q  <= addr_inc;
        prev_vld_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (go_fill) begin
            state_q    <= S_FILL;
            wr_en_q    <= 1'b1;
            cnt_q      <= '0;
            prev_vld_q <= 1'b0;
          end
        end

        S_FILL: begin
          if (bus.mode == 2'd3) begin
            state_q <= S_IDLE;
            wr_en_q <= 1'b0;
          end else if (cnt_q == AW'(PRE - 1)) begin
            state_q  <= S_ARMED;
            cnt_q    <= '0;
            to_cnt_q <= '0;
`ifdef CAPTURE_HOLDOFF_EN
            hold_cnt_q <= '0;
`endif
          end else begin
            cnt_q <= cnt_q + AW'(1);
          end
        end

        S_ARMED: begin
          if (bus.mode == 2'd3) begin
            state_q <= S_IDLE;
            wr_en_q <= 1'b0;
          end else if (real_trig || auto_trig) begin
            // A genuine crossing outranks a simultaneous timeout.
            trig_forced_q <= !real_trig;
            trig_start_q  <= trig_start;
            cnt_q         <= '0;
            if (POST_N == 0) begin
              state_q      <= S_HOLD;
              wr_en_q      <= 1'b0;
              done_q       <= 1'b1;
              start_addr_q <= trig_start;
              forced_q     <= !real_trig;
            end else begin
              state_q <= S_POST;
            end
          end else begin
`ifdef CAPTURE_HOLDOFF_EN
            if (!det_en) begin
              hold_cnt_q <= hold_cnt_q + 16'd1;
            end else if (to_cnt_q < TW'(AUTO_TO)) begin
              to_cnt_q <= to_cnt_q + TW'(1);
            end
`else
            if (to_cnt_q < TW'(AUTO_TO)) begin
              to_cnt_q <= to_cnt_q + TW'(1);
            end
`endif
          end
        end

        S_POST: begin
          if (bus.mode == 2'd3) begin
            state_q <= S_IDLE;
            wr_en_q <= 1'b0;
          end else if (cnt_q == AW'(POST_LAST)) begin
            state_q      <= S_HOLD;
            wr_en_q      <= 1'b0;
            done_q       <= 1'b1;
            start_addr_q <= trig_start_q;
            forced_q     <= trig_forced_q;
          end else begin
            cnt_q <= cnt_q + AW'(1);
          end
        end

        S_HOLD: begin
          // MODE=3 here is honoured only once the display releases the frame.
          if (bus.disp_ack) begin
            done_q <= 1'b0;
            if (!bus.mode[1]) begin
              state_q    <= S_FILL;
              wr_en_q    <= 1'b1;
              cnt_q      <= '0;
              prev_vld_q <= 1'b0;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end

        default: begin
          state_q <= S_IDLE;
          wr_en_q <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.start_addr = start_addr_q;
  assign bus.forced     = forced_q;
  assign bus.done       = done_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_scope_capture_ctrl.sv
// Purpose : self-checking bench for scope_capture_ctrl (DEPTH=16, PRE=4, AUTO_TO=32).
// Latency : model outputs are updated at each rising edge and compared on the falling edge.
// Backpressure: n/a; inputs are driven on the falling edge.
module tb_scope_capture_ctrl;
  localparam int DEPTH   = 16;
  localparam int PRE     = 4;
  localparam int AW      = 4;
  localparam int AUTO_TO = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  scope_capture_ctrl_if #(.AW(AW)) bus ();

  scope_capture_ctrl #(
    .DEPTH(DEPTH), .PRE(PRE), .AW(AW), .AUTO_TO(AUTO_TO)
  ) dut (
    .cs_i (clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level reference: tracks writes per frame, the index of the trigger
  // write, and derives states/addresses from those counts.
  int m_ok = 0;
  int m_st = 0, m_addr = 0, m_data = 0, m_start = 0, m_forced = 0;
  int m_nw = 0, m_trig_k = -1, m_T = 0, m_pf = 0, m_lastw = 0;

  always @(posedge clk) begin : model
    int cur, k, j, h, lvl, real_t, auto_t;
    if (rst) begin
      m_ok = 1; m_st = 0; m_addr = 0; m_data = 0; m_start = 0; m_forced = 0;
      m_nw = 0; m_trig_k = -1;
    end else begin
      cur    = m_data;
      m_data = int'(bus.sample);
      lvl    = int'(bus.trig_level);
`ifdef CAPTURE_HOLDOFF_EN
      h = int'(bus.holdoff);
`else
      h = 0;
`endif
      case (m_st)
        0: if (bus.mode < 2 || (bus.mode == 2 && bus.arm)) begin
             m_st = 1; m_nw = 0; m_trig_k = -1;
           end
        1, 2, 3: begin
          k = m_nw;
          if (bus.mode == 3) begin
            m_st = 0; m_addr = (m_addr + 1) % DEPTH;
          end else begin
            if (m_st == 2) begin
              j = k - PRE;
              if (j >= h) begin
                real_t = (k > 0) && (bus.trig_fall ? (m_lastw >= lvl && cur < lvl)
                                                   : (m_lastw < lvl && cur >= lvl));
                auto_t = (bus.mode == 0) && (j - h >= AUTO_TO);
                if (real_t || auto_t) begin
                  m_trig_k = k; m_T = m_addr; m_pf = real_t ? 0 : 1;
                end
              end
            end
            m_lastw = cur;
            m_nw++;
            m_addr = (m_addr + 1) % DEPTH;
            if (m_nw < PRE) m_st = 1;
            else if (m_trig_k < 0) m_st = 2;
            else if (m_nw < m_trig_k + DEPTH - PRE) m_st = 3;
            else begin
              m_st = 4; m_start = (m_T + DEPTH - PRE) % DEPTH; m_forced = m_pf;
            end
          end
        end
        4: if (bus.disp_ack) begin
             if (bus.mode < 2) begin m_st = 1; m_nw = 0; m_trig_k = -1; end
             else m_st = 0;
           end
        default: m_st = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_ok != 0) begin
      check("state",      int'(bus.state),      m_st);
      check("wr_en",      int'(bus.wr_en),      (m_st >= 1 && m_st <= 3) ? 1 : 0);
      check("wr_addr",    int'(bus.wr_addr),    m_addr);
      check("wr_data",    int'(bus.wr_data),    m_data);
      check("start_addr", int'(bus.start_addr), m_start);
      check("forced",     int'(bus.forced),     m_forced);
      check("done",       int'(bus.done),       (m_st == 4) ? 1 : 0);
    end
  end

  task automatic hold_checks(input string tag, input int st, input int start,
                             input int addr, input int forced);
    check({tag, "_state"},  int'(bus.state),      st);
    check({tag, "_start"},  int'(bus.start_addr), start);
    check({tag, "_addr"},   int'(bus.wr_addr),    addr);
    check({tag, "_forced"}, int'(bus.forced),     forced);
    check({tag, "_done"},   int'(bus.done),       (st == 4) ? 1 : 0);
  endtask

  initial begin : stim
    int a, p;
    bus.sample = 12'h000; bus.trig_level = 12'h800; bus.trig_fall = 1'b0;
    bus.mode = 2'd3; bus.arm = 1'b0; bus.disp_ack = 1'b0;
`ifdef CAPTURE_HOLDOFF_EN
    bus.holdoff = 16'd0;
`endif
    repeat (2) @(negedge clk);
    // Reset state
    check("rst_state", int'(bus.state), 0);
    check("rst_wr_en", int'(bus.wr_en), 0);
    check("rst_addr",  int'(bus.wr_addr), 0);
    check("rst_data",  int'(bus.wr_data), 0);
    check("rst_done",  int'(bus.done), 0);
    check("rst_forced", int'(bus.forced), 0);
    check("rst_start", int'(bus.start_addr), 0);

    // Normal rising trigger on a ramp: trigger write at address 8
    rst = 1'b0; bus.mode = 2'd1; bus.sample = 12'h000;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      bus.sample = 12'((k * 256) & 12'hFFF);
    end
    hold_checks("ramp", 4, 4, 4, 0);

    // Wrap boundary: trigger at address 14, last write at 9, start 10
    bus.disp_ack = 1'b1; bus.sample = 12'h100;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      bus.disp_ack = 1'b0;
      bus.sample = (k == 10) ? 12'h900 : 12'h100;
    end
    hold_checks("wrap", 4, 10, 10, 0);

    // Auto timeout with a flat input
    a = -1; p = -1;
    bus.disp_ack = 1'b1; bus.mode = 2'd0; bus.sample = 12'h100;
    for (int k = 1; k <= 52; k++) begin
      @(negedge clk);
      bus.disp_ack = 1'b0;
      if (bus.state == 3'd2 && a < 0) a = k;
      if (bus.state == 3'd3 && p < 0) p = k;
    end
    check("auto_delay", p - a, 33);
    hold_checks("auto", 4, 10, 10, 1);

    // Real crossing on the same cycle as the timeout
    bus.disp_ack = 1'b1; bus.sample = 12'h100;
    for (int k = 1; k <= 52; k++) begin
      @(negedge clk);
      bus.disp_ack = 1'b0;
      bus.sample = (k == 36) ? 12'h900 : 12'h100;
    end
    hold_checks("auto_tie", 4, 10, 10, 0);

    // Falling trigger at address 0: start wraps backwards to 12
    bus.disp_ack = 1'b1; bus.mode = 2'd1; bus.trig_fall = 1'b1; bus.sample = 12'hA00;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      bus.disp_ack = 1'b0;
      bus.sample = (k >= 6) ? 12'h200 : 12'hA00;
    end
    hold_checks("fall", 4, 12, 12, 0);

    // Stop while ARMED discards the frame
    bus.disp_ack = 1'b1; bus.sample = 12'h200;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      bus.disp_ack = 1'b0;
      if (k == 7) bus.mode = 2'd3;
    end
    hold_checks("stop", 0, 12, 3, 0);
    check("stop_wr_en", int'(bus.wr_en), 0);

    // Single mode: idle without ARM, one frame per ARM, mid-frame ARM ignored
    bus.trig_fall = 1'b0; bus.mode = 2'd2; bus.sample = 12'h100;
    repeat (50) @(negedge clk);
    check("single_idle_state", int'(bus.state), 0);
    check("single_idle_addr",  int'(bus.wr_addr), 3);
    bus.arm = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      @(negedge clk);
      bus.arm = (k == 8);
      bus.sample = (k == 10) ? 12'h900 : 12'h100;
    end
    hold_checks("single", 4, 9, 9, 0);
    bus.disp_ack = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      bus.disp_ack = 1'b0;
    end
    hold_checks("single_end", 0, 9, 9, 0);
    check("single_end_wr_en", int'(bus.wr_en), 0);

    // Reset during POST
    bus.mode = 2'd1; bus.sample = 12'h100;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      bus.sample = (k == 5) ? 12'h900 : 12'h100;
      if (k == 8) begin
        check("pre_rst_state", int'(bus.state), 3);
        rst = 1'b1;
      end
      if (k == 9) begin
        check("post_rst_state", int'(bus.state), 0);
        check("post_rst_wr_en", int'(bus.wr_en), 0);
        check("post_rst_addr",  int'(bus.wr_addr), 0);
        check("post_rst_done",  int'(bus.done), 0);
        rst = 1'b0;
      end
      if (k == 10) begin
        check("restart_state", int'(bus.state), 1);
        check("restart_addr",  int'(bus.wr_addr), 0);
      end
    end
    bus.mode = 2'd3;
    repeat (3) @(negedge clk);

`ifdef CAPTURE_HOLDOFF_EN
    // Holdoff of 5: crossing 3 cycles into ARMED ignored, 7 cycles in taken
    a = -1; p = -1;
    bus.holdoff = 16'd5; bus.mode = 2'd1; bus.sample = 12'h100;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      bus.sample = (k == 7 || k == 11) ? 12'h900 : 12'h100;
      if (bus.state == 3'd2 && a < 0) a = k;
      if (bus.state == 3'd3 && p < 0) p = k;
    end
    check("holdoff_delay", p - a, 8);
    check("holdoff_forced", int'(bus.forced), 0);
    bus.holdoff = 16'd0; bus.mode = 2'd3; bus.disp_ack = 1'b1;
    repeat (3) @(negedge clk);
    bus.disp_ack = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    bad++;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/scope_capture_ctrl.md
Name: scope_capture_ctrl

Overview:
Acquisition sequencer for one scope channel, running in the sample-clock (CS) domain. Drives the write side of the 15360-entry sample buffer and detects level/edge triggers with a programmable pre-trigger depth. Supports auto, normal and single sweep modes. Freezes the buffer after each capture until the display side acknowledges, then re-arms according to the mode.

Parameters:
DEPTH, 15360, sample buffer entries; valid range 8..16383.
PRE, 3840, pre-trigger samples kept ahead of the trigger point; must satisfy 1 <= PRE < DEPTH.
AW, 14, address width; must satisfy 2^AW >= DEPTH.
AUTO_TO, 65535, CS cycles spent in ARMED before auto mode forces a trigger.

Ports:
CS  in  1  sample clock, rising edge; the only clock
RST  in  1  synchronous reset, active-high
SAMPLE  in  12  ADC sample, valid every CS cycle
TRIG_LEVEL  in  12  trigger threshold, unsigned
TRIG_FALL  in  1  0 = rising-edge trigger, 1 = falling-edge trigger
MODE  in  2  0 = auto, 1 = normal, 2 = single, 3 = stop
ARM  in  1  one-cycle pulse; starts a sweep in single mode
DISP_ACK  in  1  level; display has consumed the frozen buffer
WR_EN  out  1  buffer write enable
WR_ADDR  out  AW  buffer write address
WR_DATA  out  12  SAMPLE delayed one cycle, aligned to WR_EN/WR_ADDR
START_ADDR  out  AW  address of the oldest sample in the frozen frame
FORCED  out  1  last capture was auto-forced, not a real trigger
DONE  out  1  frame frozen and ready
STATE  out  3  current FSM state, for debug

Behaviour:
- Reset: state IDLE; WR_EN=0, WR_ADDR=0, WR_DATA=0, START_ADDR=0, FORCED=0, DONE=0; pre-trigger and post-trigger counters cleared; prev-sample valid flag cleared.
- Reset while capturing aborts the frame. No buffer write occurs in the cycle after RST is asserted.
- States and encodings:
  - IDLE(0): leave on the next cycle if MODE is 0 or 1; leave when ARM=1 if MODE=2; stay if MODE=3. Exit goes to FILL.
  - FILL(1): write PRE samples, then go to ARMED.
  - ARMED(2): keep writing until trigger, then go to POST.
  - POST(3): write the remaining samples, then go to HOLD.
  - HOLD(4): frozen, waiting for DISP_ACK.
- Writes:
  - In FILL, ARMED and POST: WR_EN=1 every cycle; WR_DATA is the SAMPLE registered from the previous cycle.
  - WR_ADDR increments after each write and wraps from DEPTH-1 to 0.
  - In IDLE and HOLD, WR_EN=0 and WR_ADDR holds its value.
- Trigger detection is evaluated only in ARMED. Take prev = the previous WR_DATA and cur = the current WR_DATA.
  - Rising: prev < TRIG_LEVEL and cur >= TRIG_LEVEL.
  - Falling: prev >= TRIG_LEVEL and cur < TRIG_LEVEL.
  - The first write after entering FILL has no valid prev and never triggers.
  - The trigger sample is the one written in the detecting cycle; its address is T.
- Auto mode: if MODE=0 and ARMED lasts AUTO_TO cycles without a trigger, force a trigger on the current write and set FORCED=1. A real trigger sets FORCED=0.
- POST: after the write at T, perform exactly DEPTH-PRE-1 further writes. The last write is at (T+DEPTH-PRE-1) mod DEPTH.
- Frame completion:
  - On entering HOLD, START_ADDR = (T-PRE) mod DEPTH, computed without negative intermediates, and DONE=1 from the first HOLD cycle.
  - DONE stays at 1 until DISP_ACK is sampled high.
- Leaving HOLD when DISP_ACK=1:
  - MODE=0 or 1: go to FILL.
  - MODE=2 or 3: go to IDLE.
  - DONE drops in the same cycle.
- Setting MODE=3 in FILL, ARMED or POST returns to IDLE on the next cycle with DONE=0 and the frame discarded. Setting MODE=3 in HOLD takes effect only after DISP_ACK.
- If ARM is asserted outside IDLE, it is ignored.
- If a trigger and an AUTO_TO expiry occur in the same cycle, the real trigger wins and FORCED=0.
- TRIG_LEVEL, TRIG_FALL and MODE may change at any time; each takes effect on the next cycle.

Optional Feature:
CAPTURE_HOLDOFF_EN:
- Defined:
  - Adds input HOLDOFF (16 bits).
  - After entering ARMED, trigger detection is suppressed for HOLDOFF cycles while writes continue.
  - The AUTO_TO count starts only after the holdoff expires.
  - HOLDOFF=0 behaves identically to the undefined build.
- Undefined: no HOLDOFF port; trigger detection starts in the first ARMED cycle.

Test Plan:
- All tests use DEPTH=16, PRE=4, AUTO_TO=32 unless stated.
- Reset during POST: RST for 1 cycle -> next cycle STATE=0, WR_EN=0, WR_ADDR=0, DONE=0; FILL restarts with MODE=1.
- Normal rising trigger: MODE=1, TRIG_LEVEL=0x800, ramp SAMPLE 0x000 upward by 0x100 per cycle starting at FILL entry -> T is the address of the 0x800 sample. Then 11 further writes, DONE=1, START_ADDR=(T-4) mod 16, FORCED=0.
- Wrap boundary: force T=14 -> last write at address 9 (wrapped), START_ADDR=10. WR_EN stays 0 in HOLD until DISP_ACK, then FILL restarts from address 10.
- Auto timeout: MODE=0, SAMPLE held constant at 0x100 -> trigger forced exactly 32 cycles after entering ARMED, FORCED=1. Same cycle with a real crossing -> FORCED=0.
- Single mode: MODE=2, no ARM for 50 cycles -> STATE=0, no writes. ARM pulse -> one frame. After DISP_ACK, returns to IDLE; an ARM pulse mid-capture has no effect.
- Holdoff (CAPTURE_HOLDOFF_EN defined, HOLDOFF=5): a crossing 3 cycles into ARMED is ignored; a crossing 7 cycles in triggers. HOLDOFF=0 matches the undefined build cycle for cycle.
